// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// uart_tx_queue : byte FIFO feeding a UART transmitter through a one-cycle
//                 tx_start strobe and a tx_busy handshake.
// Revision 1.0
// ============================================================================
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [1:0]    state_q, state_d;
  logic          push, pop;

  always_comb begin
    // full is judged on the pre-edge contents, so a write racing a pop still drops
    push       = wr_en && !full_q && !flush;
    pop        = (state_q == IDLE) && !empty_q && !tx_busy && !flush;
    overflow_d = wr_en && full_q && !flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);

    tx_start_d = pop;
    tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;

    state_d = state_q;
    case (state_q)
      IDLE:      if (pop)      state_d = LAUNCH;
      LAUNCH:                  state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      state_q    <= IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      state_q    <= state_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// tb_uart_tx_queue : directed bench for uart_tx_queue with a tx_busy transmitter model.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk        = 1'b0;
  logic          rst        = 1'b0;
  logic          wr_en      = 1'b0;
  logic [7:0]    wr_data    = 8'h00;
  logic          flush      = 1'b0;
  logic          busy_force = 1'b0;
  logic          model_busy = 1'b0;
  logic          prev_start = 1'b0;
  logic          full, empty, overflow, tx_start, tx_busy;
  logic [CW-1:0] count;
  logic [7:0]    tx_data;

  int total     = 0;
  int bad       = 0;
  int n_starts  = 0;
  int viol      = 0;
  int busy_len  = 3;
  int busy_left = 0;
  logic [7:0] log_q [$];

  assign tx_busy = busy_force | model_busy;

  uart_tx_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  // Transmitter: busy rises the cycle after a tx_start and stays up busy_len cycles.
  always @(posedge clk) begin
    if (tx_start) begin
      n_starts++;
      log_q.push_back(tx_data);
      if (tx_busy || prev_start) viol++;
      model_busy <= 1'b1;
      busy_left  <= busy_len;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else if (busy_left == 1) begin
      busy_left  <= 0;
      model_busy <= 1'b0;
    end
    prev_start <= tx_start;
  end

  task automatic push_byte(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic settle();
    int i;
    i = 0;
    while (tx_busy && i < 1000) begin @(posedge clk); #1; i++; end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL settle_timeout busy=%0b exp=0", tx_busy); end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    total++; if (count !== 5'd0)    begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1)    begin bad++; $display("FAIL rst_empty got=%0b exp=1", empty); end
    total++; if (full !== 1'b0)     begin bad++; $display("FAIL rst_full got=%0b exp=0", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%0b exp=0", overflow); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_tx_start got=%0b exp=0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%0h exp=00", tx_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    log_q.delete();
    push_byte(8'h3C);
    total++; if (count !== 5'd1) begin bad++; $display("FAIL rst_first_write count got=%0d exp=1", count); end
    for (int i = 0; i < 100 && log_q.size() < 1; i++) begin @(posedge clk); #1; end
    total++; if (log_q.size() != 1) begin bad++; $display("FAIL rst_first_tx size got=%0d exp=1", log_q.size()); end
    else begin
      total++; if (log_q[0] !== 8'h3C) begin bad++; $display("FAIL rst_first_tx data got=%0h exp=3c", log_q[0]); end
    end
    settle();
  endtask

  task automatic test_single();
    settle();
    log_q.delete();
    push_byte(8'h55);
    total++; if (count !== 5'd1)    begin bad++; $display("FAIL single_count_k got=%0d exp=1", count); end
    total++; if (empty !== 1'b0)    begin bad++; $display("FAIL single_empty_k got=%0b exp=0", empty); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_k got=%0b exp=0", tx_start); end
    @(posedge clk); #1;
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_start_k1 got=%0b exp=1", tx_start); end
    total++; if (tx_data !== 8'h55) begin bad++; $display("FAIL single_data got=%0h exp=55", tx_data); end
    total++; if (count !== 5'd0)    begin bad++; $display("FAIL single_count_k1 got=%0d exp=0", count); end
    total++; if (empty !== 1'b1)    begin bad++; $display("FAIL single_empty_k1 got=%0b exp=1", empty); end
    @(posedge clk); #1;
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_pulse_width got=%0b exp=0", tx_start); end
    settle();
    total++; if (tx_data !== 8'h55) begin bad++; $display("FAIL single_data_hold got=%0h exp=55", tx_data); end
  endtask

  task automatic test_burst();
    logic ov_seen;
    settle();
    log_q.delete();
    busy_force = 1'b1;
    ov_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i + 1));
      ov_seen = ov_seen | overflow;
    end
    total++; if (full !== 1'b1)   begin bad++; $display("FAIL burst_full got=%0b exp=1", full); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL burst_count got=%0d exp=16", count); end
    total++; if (ov_seen !== 1'b0) begin bad++; $display("FAIL burst_no_overflow got=%0b exp=0", ov_seen); end
    push_byte(8'hAA);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL burst_ovf_pulse got=%0b exp=1", overflow); end
    total++; if (count !== 5'd16)   begin bad++; $display("FAIL burst_ovf_count got=%0d exp=16", count); end
    // Release the transmitter and write again at the same edge the pop happens.
    busy_force = 1'b0;
    push_byte(8'hBB);
    total++; if (count !== 5'd15)   begin bad++; $display("FAIL fullpop_count got=%0d exp=15", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fullpop_ovf got=%0b exp=1", overflow); end
    total++; if (full !== 1'b0)     begin bad++; $display("FAIL fullpop_full got=%0b exp=0", full); end
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL fullpop_start got=%0b exp=1", tx_start); end
    @(posedge clk); #1;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL burst_ovf_one_cycle got=%0b exp=0", overflow); end
    for (int i = 0; i < 2000 && log_q.size() < 16; i++) begin @(posedge clk); #1; end
    settle();
    total++; if (log_q.size() != 16) begin bad++; $display("FAIL burst_out_size got=%0d exp=16", log_q.size()); end
    for (int i = 0; i < 16 && i < log_q.size(); i++) begin
      total++; if (log_q[i] !== 8'(i + 1)) begin bad++; $display("FAIL burst_order[%0d] got=%0h exp=%0h", i, log_q[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_simul_rw();
    settle();
    log_q.delete();
    busy_force = 1'b1;
    push_byte(8'h11);
    push_byte(8'h22);
    busy_force = 1'b0;
    push_byte(8'h33);
    total++; if (count !== 5'd2)    begin bad++; $display("FAIL simul_count got=%0d exp=2", count); end
    total++; if (tx_data !== 8'h11) begin bad++; $display("FAIL simul_data got=%0h exp=11", tx_data); end
    for (int i = 0; i < 500 && log_q.size() < 3; i++) begin @(posedge clk); #1; end
    settle();
    total++; if (log_q.size() != 3) begin bad++; $display("FAIL simul_size got=%0d exp=3", log_q.size()); end
    else begin
      total++; if (log_q[1] !== 8'h22) begin bad++; $display("FAIL simul_order1 got=%0h exp=22", log_q[1]); end
      total++; if (log_q[2] !== 8'h33) begin bad++; $display("FAIL simul_order2 got=%0h exp=33", log_q[2]); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    for (int r = 0; r < 3; r++) begin
      settle();
      log_q.delete();
      busy_force = 1'b1;
      for (int i = 0; i < 10; i++) push_byte(8'(8'h40 + r * 10 + i));
      total++; if (count !== 5'd10) begin bad++; $display("FAIL wrap%0d_count got=%0d exp=10", r, count); end
      busy_force = 1'b0;
      for (int i = 0; i < 1000 && log_q.size() < 10; i++) begin @(posedge clk); #1; end
      settle();
      total++; if (log_q.size() != 10) begin bad++; $display("FAIL wrap%0d_size got=%0d exp=10", r, log_q.size()); end
      for (int i = 0; i < 10 && i < log_q.size(); i++) begin
        v = 8'(8'h40 + r * 10 + i);
        total++; if (log_q[i] !== v) begin bad++; $display("FAIL wrap%0d_order[%0d] got=%0h exp=%0h", r, i, log_q[i], v); end
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap%0d_empty got=%0b exp=1", r, empty); end
    end
  endtask

  task automatic test_handshake();
    int s0;
    settle();
    log_q.delete();
    busy_len = 100;
    s0 = n_starts;
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    for (int i = 0; i < 1000 && log_q.size() < 3; i++) begin @(posedge clk); #1; end
    settle();
    total++; if (n_starts - s0 != 3) begin bad++; $display("FAIL hs_starts got=%0d exp=3", n_starts - s0); end
    total++; if (log_q.size() != 3) begin bad++; $display("FAIL hs_size got=%0d exp=3", log_q.size()); end
    else begin
      total++; if (log_q[0] !== 8'hA1 || log_q[1] !== 8'hA2 || log_q[2] !== 8'hA3)
        begin bad++; $display("FAIL hs_order got=%0h,%0h,%0h exp=a1,a2,a3", log_q[0], log_q[1], log_q[2]); end
    end
    busy_len = 3;
  endtask

  task automatic test_flush();
    settle();
    log_q.delete();
    busy_len = 20;
    for (int i = 0; i < 5; i++) push_byte(8'(8'hC1 + i));
    total++; if (count !== 5'd4) begin bad++; $display("FAIL flush_pre_count got=%0d exp=4", count); end
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    @(posedge clk); #1;
    flush = 1'b0; wr_en = 1'b0;
    total++; if (count !== 5'd0)    begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1)    begin bad++; $display("FAIL flush_empty got=%0b exp=1", empty); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL flush_overflow got=%0b exp=0", overflow); end
    repeat (60) begin @(posedge clk); #1; end
    total++; if (log_q.size() != 1) begin bad++; $display("FAIL flush_starts got=%0d exp=1", log_q.size()); end
    total++; if (tx_data !== 8'hC1) begin bad++; $display("FAIL flush_data_hold got=%0h exp=c1", tx_data); end
    busy_len = 3;
  endtask

  task automatic test_reset_mid();
    int s0;
    settle();
    busy_len = 50;
    s0 = n_starts;
    for (int i = 0; i < 4; i++) push_byte(8'(8'hD1 + i));
    total++; if (count !== 5'd3) begin bad++; $display("FAIL rmid_pre_count got=%0d exp=3", count); end
    repeat (2) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    total++; if (count !== 5'd0)    begin bad++; $display("FAIL rmid_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1)    begin bad++; $display("FAIL rmid_empty got=%0b exp=1", empty); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rmid_tx_data got=%0h exp=00", tx_data); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rmid_tx_start got=%0b exp=0", tx_start); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (150) begin @(posedge clk); #1; end
    total++; if (n_starts - s0 != 1) begin bad++; $display("FAIL rmid_no_start got=%0d exp=1", n_starts - s0); end
    busy_len = 3;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_simul_rw();
    test_wrap();
    test_handshake();
    test_flush();
    test_reset_mid();
    total++; if (viol != 0) begin bad++; $display("FAIL handshake_violations got=%0d exp=0", viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
